// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: one-hot status codes, instruction codes, the
// "no register" ID and the default datapath width.
package y86_pkg;

    localparam int W_DATA_DEFAULT = 64;

    localparam logic [3:0] STAT_AOK = 4'b0001;
    localparam logic [3:0] STAT_HLT = 4'b0010;
    localparam logic [3:0] STAT_ADR = 4'b0100;
    localparam logic [3:0] STAT_INS = 4'b1000;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;

endpackage

// File: rtl/pipe_field_reg.sv
// Generic pipeline register slice: reset beats stall, stall beats bubble,
// bubble beats load.
module pipe_field_reg #(
    parameter int             W          = 1,
    parameter logic [W-1:0]   BUBBLE_VAL = '0,
    parameter logic [W-1:0]   RESET_VAL  = BUBBLE_VAL
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stall,
    input  logic         bubble,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= RESET_VAL;
        end else if (!stall) begin
            if (bubble) begin
                q <= BUBBLE_VAL;
            end else begin
                q <= d;
            end
        end
    end

endmodule

// File: rtl/pipe_reg_bank.sv
// All inter-stage registers of the Y86-64 pipeline (F, D, E, M, W), each
// built from one packed pipe_field_reg so a stage moves atomically.
module pipe_reg_bank
    import y86_pkg::*;
#(
    parameter int                W_DATA   = W_DATA_DEFAULT,
    parameter logic [W_DATA-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              F_stall,
    input  logic              D_stall,
    input  logic              W_stall,
    input  logic              D_bubble,
    input  logic              E_bubble,
    input  logic              M_bubble,
    input  logic [W_DATA-1:0] f_predPC,
    input  logic [3:0]        f_stat,
    input  logic [3:0]        f_icode,
    input  logic [3:0]        f_ifun,
    input  logic [3:0]        f_rA,
    input  logic [3:0]        f_rB,
    input  logic [W_DATA-1:0] f_valC,
    input  logic [W_DATA-1:0] f_valP,
    input  logic [3:0]        d_stat,
    input  logic [3:0]        d_icode,
    input  logic [3:0]        d_ifun,
    input  logic [3:0]        d_dstE,
    input  logic [3:0]        d_dstM,
    input  logic [3:0]        d_srcA,
    input  logic [3:0]        d_srcB,
    input  logic [W_DATA-1:0] d_valC,
    input  logic [W_DATA-1:0] d_valA,
    input  logic [W_DATA-1:0] d_valB,
    input  logic [3:0]        e_stat,
    input  logic [3:0]        e_icode,
    input  logic [3:0]        e_dstE,
    input  logic [3:0]        e_dstM,
    input  logic              e_Cnd,
    input  logic [W_DATA-1:0] e_valE,
    input  logic [W_DATA-1:0] e_valA,
    input  logic [3:0]        m_stat,
    input  logic [3:0]        m_icode,
    input  logic [3:0]        m_dstE,
    input  logic [3:0]        m_dstM,
    input  logic [W_DATA-1:0] m_valE,
    input  logic [W_DATA-1:0] m_valM,
    output logic [W_DATA-1:0] F_predPC,
    output logic [3:0]        D_stat,
    output logic [3:0]        D_icode,
    output logic [3:0]        D_ifun,
    output logic [3:0]        D_rA,
    output logic [3:0]        D_rB,
    output logic [W_DATA-1:0] D_valC,
    output logic [W_DATA-1:0] D_valP,
    output logic [3:0]        E_stat,
    output logic [3:0]        E_icode,
    output logic [3:0]        E_ifun,
    output logic [3:0]        E_dstE,
    output logic [3:0]        E_dstM,
    output logic [3:0]        E_srcA,
    output logic [3:0]        E_srcB,
    output logic [W_DATA-1:0] E_valC,
    output logic [W_DATA-1:0] E_valA,
    output logic [W_DATA-1:0] E_valB,
    output logic [3:0]        M_stat,
    output logic [3:0]        M_icode,
    output logic [3:0]        M_dstE,
    output logic [3:0]        M_dstM,
    output logic              M_Cnd,
    output logic [W_DATA-1:0] M_valE,
    output logic [W_DATA-1:0] M_valA,
    output logic [3:0]        W_stat,
    output logic [3:0]        W_icode,
    output logic [3:0]        W_dstE,
    output logic [3:0]        W_dstM,
    output logic [W_DATA-1:0] W_valE,
    output logic [W_DATA-1:0] W_valM
);

    localparam int D_W = 20 + 2 * W_DATA;
    localparam int E_W = 28 + 3 * W_DATA;
    localparam int M_W = 17 + 2 * W_DATA;
    localparam int W_W = 16 + 2 * W_DATA;

    // Nop images: AOK status, INOP, ifun 0, every register ID RNONE, data 0.
    localparam logic [D_W-1:0] D_NOP =
        {STAT_AOK, INOP, 4'h0, RNONE, RNONE, {(2 * W_DATA){1'b0}}};
    localparam logic [E_W-1:0] E_NOP =
        {STAT_AOK, INOP, 4'h0, RNONE, RNONE, RNONE, RNONE, {(3 * W_DATA){1'b0}}};
    localparam logic [M_W-1:0] M_NOP =
        {STAT_AOK, INOP, RNONE, RNONE, 1'b0, {(2 * W_DATA){1'b0}}};
    localparam logic [W_W-1:0] W_NOP =
        {STAT_AOK, INOP, RNONE, RNONE, {(2 * W_DATA){1'b0}}};

    logic [D_W-1:0] d_next, d_q;
    logic [E_W-1:0] e_next, e_q;
    logic [M_W-1:0] m_next, m_q;
    logic [W_W-1:0] w_next, w_q;

    assign d_next = {f_stat, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP};
    assign e_next = {d_stat, d_icode, d_ifun, d_dstE, d_dstM, d_srcA, d_srcB,
                     d_valC, d_valA, d_valB};
    assign m_next = {e_stat, e_icode, e_dstE, e_dstM, e_Cnd, e_valE, e_valA};
    assign w_next = {m_stat, m_icode, m_dstE, m_dstM, m_valE, m_valM};

    pipe_field_reg #(.W(W_DATA), .BUBBLE_VAL('0), .RESET_VAL(RESET_PC)) u_f_reg (
        .clk(clk), .rst_n(rst_n), .stall(F_stall), .bubble(1'b0),
        .d(f_predPC), .q(F_predPC)
    );

    pipe_field_reg #(.W(D_W), .BUBBLE_VAL(D_NOP)) u_d_reg (
        .clk(clk), .rst_n(rst_n), .stall(D_stall), .bubble(D_bubble),
        .d(d_next), .q(d_q)
    );

    pipe_field_reg #(.W(E_W), .BUBBLE_VAL(E_NOP)) u_e_reg (
        .clk(clk), .rst_n(rst_n), .stall(1'b0), .bubble(E_bubble),
        .d(e_next), .q(e_q)
    );

    pipe_field_reg #(.W(M_W), .BUBBLE_VAL(M_NOP)) u_m_reg (
        .clk(clk), .rst_n(rst_n), .stall(1'b0), .bubble(M_bubble),
        .d(m_next), .q(m_q)
    );

    pipe_field_reg #(.W(W_W), .BUBBLE_VAL(W_NOP)) u_w_reg (
        .clk(clk), .rst_n(rst_n), .stall(W_stall), .bubble(1'b0),
        .d(w_next), .q(w_q)
    );

    assign {D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP} = d_q;
    assign {E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB,
            E_valC, E_valA, E_valB} = e_q;
    assign {M_stat, M_icode, M_dstE, M_dstM, M_Cnd, M_valE, M_valA} = m_q;
    assign {W_stat, W_icode, W_dstE, W_dstM, W_valE, W_valM} = w_q;

endmodule

// File: tb/tb_pipe_reg_bank.sv
// Bench for pipe_reg_bank: directed pipeline scenarios followed by random
// traffic, all compared against a stage-record reference model.
module tb_pipe_reg_bank;

    typedef struct packed {
        logic [3:0] stat, icode, ifun, ra, rb;
        logic [63:0] valc, valp;
    } d_rec_t;
    typedef struct packed {
        logic [3:0] stat, icode, ifun, dste, dstm, srca, srcb;
        logic [63:0] valc, vala, valb;
    } e_rec_t;
    typedef struct packed {
        logic [3:0] stat, icode, dste, dstm;
        logic cnd;
        logic [63:0] vale, vala;
    } m_rec_t;
    typedef struct packed {
        logic [3:0] stat, icode, dste, dstm;
        logic [63:0] vale, valm;
    } w_rec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble;
    logic [63:0] f_predPC, f_valC, f_valP, d_valC, d_valA, d_valB;
    logic [63:0] e_valE, e_valA, m_valE, m_valM;
    logic [3:0] f_stat, f_icode, f_ifun, f_rA, f_rB;
    logic [3:0] d_stat, d_icode, d_ifun, d_dstE, d_dstM, d_srcA, d_srcB;
    logic [3:0] e_stat, e_icode, e_dstE, e_dstM, m_stat, m_icode, m_dstE, m_dstM;
    logic e_Cnd;
    logic [63:0] F_predPC, D_valC, D_valP, E_valC, E_valA, E_valB;
    logic [63:0] M_valE, M_valA, W_valE, W_valM;
    logic [3:0] D_stat, D_icode, D_ifun, D_rA, D_rB;
    logic [3:0] E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
    logic [3:0] M_stat, M_icode, M_dstE, M_dstM, W_stat, W_icode, W_dstE, W_dstM;
    logic M_Cnd;

    int n_checks = 0;
    int n_fail = 0;

    logic [63:0] mf;
    d_rec_t md;
    e_rec_t me;
    m_rec_t mm;
    w_rec_t mw;

    pipe_reg_bank #(.W_DATA(64), .RESET_PC(64'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .F_stall(F_stall), .D_stall(D_stall), .W_stall(W_stall),
        .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble),
        .f_predPC(f_predPC), .f_stat(f_stat), .f_icode(f_icode), .f_ifun(f_ifun),
        .f_rA(f_rA), .f_rB(f_rB), .f_valC(f_valC), .f_valP(f_valP),
        .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun), .d_dstE(d_dstE),
        .d_dstM(d_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .d_valC(d_valC), .d_valA(d_valA), .d_valB(d_valB),
        .e_stat(e_stat), .e_icode(e_icode), .e_dstE(e_dstE), .e_dstM(e_dstM),
        .e_Cnd(e_Cnd), .e_valE(e_valE), .e_valA(e_valA),
        .m_stat(m_stat), .m_icode(m_icode), .m_dstE(m_dstE), .m_dstM(m_dstM),
        .m_valE(m_valE), .m_valM(m_valM),
        .F_predPC(F_predPC),
        .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA),
        .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun), .E_dstE(E_dstE),
        .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB),
        .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
        .M_stat(M_stat), .M_icode(M_icode), .M_dstE(M_dstE), .M_dstM(M_dstM),
        .M_Cnd(M_Cnd), .M_valE(M_valE), .M_valA(M_valA),
        .W_stat(W_stat), .W_icode(W_icode), .W_dstE(W_dstE), .W_dstM(W_dstM),
        .W_valE(W_valE), .W_valM(W_valM)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] r64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: each stage record follows reset > stall > bubble > load.
    task automatic model_step();
        d_rec_t d_nop;
        e_rec_t e_nop;
        m_rec_t m_nop;
        w_rec_t w_nop;
        d_nop = '{stat: 4'b0001, icode: 4'h1, ifun: 4'h0, ra: 4'hF, rb: 4'hF, valc: 64'h0, valp: 64'h0};
        e_nop = '{stat: 4'b0001, icode: 4'h1, ifun: 4'h0, dste: 4'hF, dstm: 4'hF,
                  srca: 4'hF, srcb: 4'hF, valc: 64'h0, vala: 64'h0, valb: 64'h0};
        m_nop = '{stat: 4'b0001, icode: 4'h1, dste: 4'hF, dstm: 4'hF, cnd: 1'b0, vale: 64'h0, vala: 64'h0};
        w_nop = '{stat: 4'b0001, icode: 4'h1, dste: 4'hF, dstm: 4'hF, vale: 64'h0, valm: 64'h0};
        if (!rst_n) begin
            mf = 64'h0;
            md = d_nop; me = e_nop; mm = m_nop; mw = w_nop;
        end else begin
            if (!F_stall) mf = f_predPC;
            if (!D_stall) md = D_bubble ? d_nop :
                '{stat: f_stat, icode: f_icode, ifun: f_ifun, ra: f_rA, rb: f_rB, valc: f_valC, valp: f_valP};
            me = E_bubble ? e_nop :
                '{stat: d_stat, icode: d_icode, ifun: d_ifun, dste: d_dstE, dstm: d_dstM,
                  srca: d_srcA, srcb: d_srcB, valc: d_valC, vala: d_valA, valb: d_valB};
            mm = M_bubble ? m_nop :
                '{stat: e_stat, icode: e_icode, dste: e_dstE, dstm: e_dstM, cnd: e_Cnd, vale: e_valE, vala: e_valA};
            if (!W_stall) mw = '{stat: m_stat, icode: m_icode, dste: m_dstE, dstm: m_dstM, vale: m_valE, valm: m_valM};
        end
    endtask

    task automatic check_all(input string tag);
        d_rec_t od;
        e_rec_t oe;
        m_rec_t om;
        w_rec_t ow;
        od = {D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP};
        oe = {E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB, E_valC, E_valA, E_valB};
        om = {M_stat, M_icode, M_dstE, M_dstM, M_Cnd, M_valE, M_valA};
        ow = {W_stat, W_icode, W_dstE, W_dstM, W_valE, W_valM};
        check({tag, ".F"}, 256'(F_predPC), 256'(mf));
        check({tag, ".D"}, 256'(od), 256'(md));
        check({tag, ".E"}, 256'(oe), 256'(me));
        check({tag, ".M"}, 256'(om), 256'(mm));
        check({tag, ".W"}, 256'(ow), 256'(mw));
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic rand_data();
        f_predPC = r64(); f_valC = r64(); f_valP = r64();
        {f_stat, f_icode, f_ifun, f_rA, f_rB} = 20'($urandom());
        {d_stat, d_icode, d_ifun, d_dstE, d_dstM, d_srcA, d_srcB} = 28'($urandom());
        d_valC = r64(); d_valA = r64(); d_valB = r64();
        {e_stat, e_icode, e_dstE, e_dstM, e_Cnd} = 17'($urandom());
        e_valE = r64(); e_valA = r64();
        {m_stat, m_icode, m_dstE, m_dstM} = 16'($urandom());
        m_valE = r64(); m_valM = r64();
    endtask

    task automatic set_ctrl(input logic fs, ds, ws, db, eb, mb);
        F_stall = fs; D_stall = ds; W_stall = ws;
        D_bubble = db; E_bubble = eb; M_bubble = mb;
    endtask

    initial begin
        logic [63:0] held_vale;
        d_rec_t held_d;
        logic [63:0] held_pc;

        // Reset with random inputs and controls for two edges
        rst_n = 1'b0;
        mf = '0; md = '0; me = '0; mm = '0; mw = '0;
        for (int i = 0; i < 2; i++) begin
            rand_data();
            {F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble} = 6'($urandom());
            @(negedge clk);
        end
        @(posedge clk);
        model_step();
        #1;
        check_all("reset");
        check("reset.F_predPC", 256'(F_predPC), 256'(64'h0));
        check("reset.icodes", 256'({D_icode, E_icode, M_icode, W_icode}), 256'(16'h1111));
        check("reset.regids", 256'({D_rA, D_rB, E_dstE, E_dstM, E_srcA, E_srcB, M_dstE, M_dstM, W_dstE, W_dstM}),
              256'(40'hFF_FFFF_FFFF));
        check("reset.stats", 256'({D_stat, E_stat, M_stat, W_stat}), 256'(16'h1111));

        // Straight flow: irmovq into D, then into E
        rst_n = 1'b1;
        set_ctrl(0, 0, 0, 0, 0, 0);
        rand_data();
        f_stat = 4'b0001; f_icode = 4'h3; f_ifun = 4'h0; f_rA = 4'hF; f_rB = 4'h2;
        f_valC = 64'h10; f_valP = 64'h0A; f_predPC = 64'h0A;
        cycle("flow1");
        check("flow.D_icode", 256'(D_icode), 256'(4'h3));
        check("flow.D_valC", 256'(D_valC), 256'(64'h10));
        rand_data();
        d_stat = md.stat; d_icode = md.icode; d_ifun = md.ifun;
        d_dstE = md.rb; d_dstM = 4'hF; d_srcA = 4'hF; d_srcB = 4'hF;
        d_valC = md.valc; d_valA = 64'h0; d_valB = 64'h0;
        cycle("flow2");
        check("flow.E_icode", 256'(E_icode), 256'(4'h3));
        check("flow.E_dstE", 256'(E_dstE), 256'(4'h2));

        // Load-use stall
        held_d = md;
        held_pc = mf;
        rand_data();
        set_ctrl(1, 1, 0, 0, 1, 0);
        cycle("loaduse");
        check("loaduse.F_hold", 256'(F_predPC), 256'(held_pc));
        check("loaduse.D_hold", 256'({D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP}), 256'(held_d));
        check("loaduse.E_nop", 256'({E_icode, E_dstE, E_dstM}), 256'(12'h1FF));
        check("loaduse.M_icode", 256'(M_icode), 256'(e_icode));

        // Branch mispredict
        rand_data();
        e_icode = 4'h7; e_Cnd = 1'b0;
        set_ctrl(0, 0, 0, 1, 1, 0);
        cycle("mispred");
        check("mispred.M", 256'({M_icode, M_Cnd}), 256'({4'h7, 1'b0}));
        check("mispred.DE_icode", 256'({D_icode, E_icode}), 256'(8'h11));

        // Exception reaching W, then W frozen
        rand_data();
        m_stat = 4'b0100;
        set_ctrl(0, 0, 0, 0, 0, 1);
        cycle("exc_load");
        check("exc.W_stat", 256'(W_stat), 256'(4'b0100));
        held_vale = mw.vale;
        for (int i = 0; i < 5; i++) begin
            rand_data();
            set_ctrl(0, 0, 1, 0, 0, 1);
            cycle("exc_hold");
            check("exc.W_stat_hold", 256'(W_stat), 256'(4'b0100));
            check("exc.W_valE_hold", 256'(W_valE), 256'(held_vale));
            check("exc.M_icode", 256'(M_icode), 256'(4'h1));
        end

        // Conflicting D controls: stall wins; reset overrides everything
        held_d = md;
        rand_data();
        set_ctrl(0, 1, 0, 1, 0, 0);
        cycle("conflict");
        check("conflict.D_hold", 256'({D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP}), 256'(held_d));
        rand_data();
        set_ctrl(1, 1, 1, 1, 1, 1);
        rst_n = 1'b0;
        cycle("midreset");
        check("midreset.F_predPC", 256'(F_predPC), 256'(64'h0));
        check("midreset.W_stat", 256'({W_stat, W_icode}), 256'(8'h11));

        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            rand_data();
            rst_n = ($urandom_range(0, 39) != 0);
            F_stall  = ($urandom_range(0, 3) == 0);
            D_stall  = ($urandom_range(0, 3) == 0);
            W_stall  = ($urandom_range(0, 4) == 0);
            D_bubble = ($urandom_range(0, 3) == 0);
            E_bubble = ($urandom_range(0, 3) == 0);
            M_bubble = ($urandom_range(0, 3) == 0);
            cycle("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
